fpu_flag_accum: RTL and testbench
=================================

Name: fpu_flag_accum

Overview:
- Parametrised, pipelined successor to the FMA combinational flag generator.
- Computes IEEE/RISC-V exception flags for NCH independent FP result channels (FMA, divide/sqrt, convert, ...) and registers them per channel.
- Accumulates flags of retiring operations into the sticky fflags register (NV DZ OF UF NX, bits 4..0).
- Sits between the FPU execution units and the CSR file; supports stall, flush and CSR write/set/clear.

Parameters:
NCH, 2, number of result channels (1..8)
FLEN_TAG, 0, reserved; must be 0 (no tag tracking in this generation)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  NCH  channel c presents a result this cycle
stall  input  1  hold stage-1 registers (no load, valid retained)
flush  input  1  kill all stage-1 entries
snan_in  input  NCH  any operand is a signalling NaN
inf_sub  input  NCH  Inf - Inf (effective subtraction of infinities)
zero_inf  input  NCH  0 * Inf
div_zero  input  NCH  finite nonzero / 0
special  input  NCH  any operand is Inf or NaN (suppresses OF/UF/NX/DZ)
ovf  input  NCH  rounded exponent exceeds max
tiny  input  NCH  result tiny after rounding
rs  input  2*NCH  round/sticky bits; channel c at [2c+1:2c]
retire  input  NCH  stage-1 entry of channel c commits this cycle
csr_we  input  1  CSR access to fflags
csr_op  input  2  00 write, 01 set, 10 clear, 11 no-op
csr_wdata  input  5  CSR operand
flags_q  output  5*NCH  registered per-channel flags; channel c at [5c+4:5c]
valid_q  output  NCH  stage-1 entry valid
fflags  output  5  sticky accumulated flags
any_nv  output  1  OR of NV over all valid_q entries (registered-path, combinational OR)

Behaviour:
- Reset (sync, clk edge with reset=1): flags_q=0, valid_q=0, fflags=0; overrides stall, flush, csr_we, retire.
- Flag generation per channel c (combinational, stage 0):
  - NV = snan_in | inf_sub | zero_inf
  - DZ = div_zero & ~special & ~NV
  - OF = ovf & ~special & ~NV
  - NXr = (rs != 0) | OF
  - NX = NXr & ~special & ~NV
  - UF = tiny & NXr & ~special & ~NV & ~OF
- Stage 1 register, latency 1:
  - If flush: valid_q <= 0; flags_q unchanged. Flush beats stall and in_valid.
  - Else if stall: hold flags_q and valid_q.
  - Else: flags_q[c] <= generated flags; valid_q[c] <= in_valid[c].
  - Flags are loaded even when in_valid=0; consumers qualify with valid_q.
- Accumulation, one cycle after retire:
  - acc = OR over c of (flags_q[c] & {5{valid_q[c] & retire[c]}}).
  - retire on an invalid entry is ignored.
  - retire with flush in the same cycle: flush does not cancel a retire presented that cycle (retire samples pre-flush valid_q).
- fflags next value:
  - Base: write→csr_wdata; set→fflags|csr_wdata; clear→fflags&~csr_wdata; no-op or csr_we=0→fflags.
  - fflags <= base | acc. Retiring flags are never lost to a same-cycle CSR write or clear.
- Stall does not block retire or CSR updates. A stalled valid entry may retire repeatedly; OR is idempotent.
- any_nv = OR over c of (valid_q[c] & flags_q[5c+4]).
- All channels are independent; simultaneous retires OR together.

Test Plan:
- Reset: drive garbage on all inputs with reset=1 for 2 cycles → flags_q=0, valid_q=0, fflags=5'b00000 on the following cycle.
- Channel 0, in_valid=1, rs=2'b01, others 0; next cycle retire[0]=1 → flags_q[4:0]=5'b00001; two cycles after input, fflags=5'b00001.
- Channel 1, zero_inf=1, ovf=1, rs=2'b11 → flags_q[9:5]=5'b10000 (OF/NX suppressed by NV); any_nv=1 one cycle later.
- Channel 0 ovf=1 and channel 1 div_zero=1 together, both retire → fflags=5'b01101 (DZ, OF, NX).
- fflags=5'b11111; csr_we=1, op=10 (clear), wdata=5'b11111 in the same cycle channel 0 retires UF|NX (tiny=1, rs=01) → fflags=5'b00011.
- valid entry, stall=1 for 3 cycles, then flush=1 with retire=0 → valid_q holds through the stall, drops to 0 after the flush; no retire afterwards changes fflags.

Source files
------------

// File: rtl/fpu_flag_accum.sv
// rtl/fpu_flag_accum.sv - per-channel FP exception flag pipeline with sticky fflags accumulation
module fpu_flag_accum #(
    parameter int NCH      = 2,
    parameter int FLEN_TAG = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [NCH-1:0]     snan_in,
    input  logic [NCH-1:0]     inf_sub,
    input  logic [NCH-1:0]     zero_inf,
    input  logic [NCH-1:0]     div_zero,
    input  logic [NCH-1:0]     special,
    input  logic [NCH-1:0]     ovf,
    input  logic [NCH-1:0]     tiny,
    input  logic [2*NCH-1:0]   rs,
    input  logic [NCH-1:0]     retire,
    input  logic               csr_we,
    input  logic [1:0]         csr_op,
    input  logic [4:0]         csr_wdata,
    output logic [5*NCH-1:0]   flags_q,
    output logic [NCH-1:0]     valid_q,
    output logic [4:0]         fflags,
    output logic               any_nv
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    if (FLEN_TAG != 0) begin : g_bad_tag
        $error("fpu_flag_accum: FLEN_TAG must be 0");
    end

    logic [5*NCH-1:0] gen_flags;
    logic [4:0]       acc;
    logic [4:0]       base;

    // Stage 0: flag generation, packed as {NV, DZ, OF, UF, NX}.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic nv, ok, dz, ov_f, nxr, nx, uf;
        assign nv   = snan_in[c] | inf_sub[c] | zero_inf[c];
        assign ok   = ~special[c] & ~nv;
        assign dz   = div_zero[c] & ok;
        assign ov_f = ovf[c] & ok;
        assign nxr  = (rs[2*c +: 2] != 2'b00) | ov_f;
        assign nx   = nxr & ok;
        // Underflow only for inexact tiny results that did not overflow.
        assign uf   = tiny[c] & nxr & ok & ~ov_f;
        assign gen_flags[5*c +: 5] = {nv, dz, ov_f, uf, nx};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (!stall) begin
            flags_q <= gen_flags;
            valid_q <= in_valid;
        end
    end

    // Retire samples the pre-flush valid_q, so a same-cycle flush cannot drop it.
    always_comb begin
        acc    = '0;
        any_nv = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            acc    = acc | (flags_q[5*c +: 5] & {5{valid_q[c] & retire[c]}});
            any_nv = any_nv | (valid_q[c] & flags_q[5*c+4]);
        end
    end

    always_comb begin
        base = fflags;
        if (csr_we) begin
            case (csr_op)
                OP_WRITE: base = csr_wdata;
                OP_SET:   base = fflags | csr_wdata;
                OP_CLEAR: base = fflags & ~csr_wdata;
                default:  base = fflags;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fflags <= '0;
        end else begin
            fflags <= base | acc;
        end
    end

endmodule

// File: tb/tb_fpu_flag_accum.sv
// tb/tb_fpu_flag_accum.sv - directed table-driven bench for fpu_flag_accum
module tb_fpu_flag_accum;

    localparam int NCH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   in_valid, snan_in, inf_sub, zero_inf, div_zero, special, ovf, tiny, retire;
    logic             stall, flush, csr_we;
    logic [2*NCH-1:0] rs;
    logic [1:0]       csr_op;
    logic [4:0]       csr_wdata;
    logic [5*NCH-1:0] flags_q;
    logic [NCH-1:0]   valid_q;
    logic [4:0]       fflags;
    logic             any_nv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_flag_accum #(.NCH(NCH), .FLEN_TAG(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .snan_in(snan_in), .inf_sub(inf_sub), .zero_inf(zero_inf), .div_zero(div_zero),
        .special(special), .ovf(ovf), .tiny(tiny), .rs(rs), .retire(retire),
        .csr_we(csr_we), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .flags_q(flags_q), .valid_q(valid_q), .fflags(fflags), .any_nv(any_nv)
    );

    typedef struct {
        string       name;
        logic [1:0]  v, sn, is, zi, dz, sp, ov, ti;
        logic [3:0]  r;
        logic [9:0]  exp_flags;
        logic        exp_nv;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid = '0; snan_in = '0; inf_sub = '0; zero_inf = '0; div_zero = '0;
        special = '0; ovf = '0; tiny = '0; rs = '0; retire = '0;
        stall = 1'b0; flush = 1'b0; csr_we = 1'b0; csr_op = 2'b11; csr_wdata = '0;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic csr(input logic [1:0] op, input logic [4:0] d);
        csr_we = 1'b1; csr_op = op; csr_wdata = d;
        tick();
        csr_we = 1'b0; csr_op = 2'b11; csr_wdata = '0;
    endtask

    task automatic apply(input vec_t t);
        in_valid = t.v; snan_in = t.sn; inf_sub = t.is; zero_inf = t.zi; div_zero = t.dz;
        special = t.sp; ovf = t.ov; tiny = t.ti; rs = t.r;
    endtask

    initial begin
        //                 name       v      sn     is     zi     dz     sp     ov     ti     rs       flags            nv
        vecs[0] = '{"nx_ch0",   2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 10'b00000_00001, 1'b0};
        vecs[1] = '{"nv_ch1",   2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 4'b1100, 10'b10000_00000, 1'b1};
        vecs[2] = '{"of_dz",    2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 4'b0000, 10'b01000_00101, 1'b0};
        vecs[3] = '{"uf_exact", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0001, 10'b00000_00011, 1'b0};
        vecs[4] = '{"special",  2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 4'b0011, 10'b10000_00000, 1'b1};
        vecs[5] = '{"of_no_uf", 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 4'b0000, 10'b10000_00101, 1'b0};
        vecs[6] = '{"invalid",  2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 4'b1000, 10'b00011_10000, 1'b0};

        idle();
        @(negedge clk);

        // Reset with garbage everywhere.
        in_valid = '1; snan_in = '1; ovf = '1; rs = '1; retire = '1; stall = 1'b1;
        csr_we = 1'b1; csr_op = 2'b00; csr_wdata = 5'h1f; flush = 1'b1;
        reset = 1'b1;
        tick(); tick();
        check("rst_flags", 32'(flags_q), 0);
        check("rst_valid", 32'(valid_q), 0);
        check("rst_fflags", 32'(fflags), 0);
        idle();

        // Flag generation table.
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            tick();
            check({vecs[i].name, "_flags"}, 32'(flags_q), 32'(vecs[i].exp_flags));
            check({vecs[i].name, "_valid"}, 32'(valid_q), 32'(vecs[i].v));
            check({vecs[i].name, "_any_nv"}, 32'(any_nv), 32'(vecs[i].exp_nv));
        end
        idle();
        check("tbl_fflags_untouched", 32'(fflags), 0);

        // Retire NX on ch0.
        apply(vecs[0]); tick(); idle();
        retire = 2'b01; tick(); retire = '0;
        check("retire_nx", 32'(fflags), 5'b00001);

        // Both channels retire together.
        csr(2'b00, 5'b00000);
        apply(vecs[2]); tick(); idle();
        retire = 2'b11; tick(); retire = '0;
        check("retire_both", 32'(fflags), 5'b01101);

        // Clear-all coinciding with a UF|NX retire.
        csr(2'b00, 5'b11111);
        check("csr_write", 32'(fflags), 5'b11111);
        apply(vecs[3]); tick(); idle();
        retire = 2'b01; csr_we = 1'b1; csr_op = 2'b10; csr_wdata = 5'b11111;
        tick(); idle();
        check("clear_vs_retire", 32'(fflags), 5'b00011);

        csr(2'b01, 5'b10000);
        check("csr_set", 32'(fflags), 5'b10011);
        csr(2'b11, 5'b00000);
        check("csr_noop", 32'(fflags), 5'b10011);
        csr_we = 1'b0; csr_op = 2'b00; tick(); csr_op = 2'b11;
        check("csr_we_low", 32'(fflags), 5'b10011);

        // Stall holds, then flush kills; later retires do nothing.
        csr(2'b00, 5'b00000);
        in_valid = 2'b01; snan_in = 2'b01; tick(); idle();
        stall = 1'b1;
        in_valid = 2'b00; ovf = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(valid_q), 2'b01);
            check("stall_flags", 32'(flags_q[4:0]), 5'b10000);
        end
        flush = 1'b1; tick(); flush = 1'b0; stall = 1'b0; idle();
        check("flush_valid", 32'(valid_q), 0);
        check("flush_flags_kept", 32'(flags_q[4:0]), 5'b10000);
        check("flush_any_nv", 32'(any_nv), 0);
        retire = 2'b11; tick(); retire = '0;
        check("retire_after_flush", 32'(fflags), 0);

        // Retire and flush in the same cycle: retire still counts.
        apply(vecs[0]); tick(); idle();
        retire = 2'b01; flush = 1'b1; tick(); idle();
        check("flush_retire_fflags", 32'(fflags), 5'b00001);
        check("flush_retire_valid", 32'(valid_q), 0);

        // Stalled entry retiring repeatedly alongside a CSR write.
        csr(2'b00, 5'b00000);
        in_valid = 2'b10; div_zero = 2'b10; tick(); idle();
        stall = 1'b1; retire = 2'b10; tick();
        csr_we = 1'b1; csr_op = 2'b00; csr_wdata = 5'b00100; tick(); idle();
        check("stall_retire_csr", 32'(fflags), 5'b01100);
        check("stall_retire_valid", 32'(valid_q), 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
